// File: rtl/host_wb_master_pkg.sv
// host_wb_master shared constants
// register map, CTRL/STATUS bit positions, FSM encoding
package host_wb_master_pkg;

  localparam int REG_CTRL  = 0;
  localparam int REG_ADDR  = 1;
  localparam int REG_WDATA = 2;
  localparam int REG_RDATA = 3;
  localparam int REG_TMO   = 4;

  localparam int CTRL_START = 0;
  localparam int CTRL_WE    = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_SEL   = 16;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_TO   = 3;
  localparam int ST_WE   = 4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/host_wb_master.sv
// host_wb_master: host register file driving
// single Wishbone classic cycles
module host_wb_master
  import host_wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_DEFAULT = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wren_i,
  input  logic                    rden_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SW = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;
  logic                  ack_q;
  logic                  busy;
  logic                  wr_ctrl;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_val;

  assign busy    = (state_q == S_ACTIVE);
  assign wr_ctrl = wren_i &&
                   (addr_i == ADDR_WIDTH'(REG_CTRL));

  assign wb_cyc_o = busy;
  assign wb_stb_o = busy;
  assign wb_we_o  = busy & we_q;
  assign wb_adr_o = busy ? addr_q : '0;
  assign wb_dat_o = busy ? wdata_q : '0;
  assign wb_sel_o = busy ? sel_q : '0;
  assign data_o   = dout_q;
  assign ack_o    = ack_q;

  // host read mux, sampled before any same-cycle write
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
    status[ST_TO]   = to_q;
    status[ST_WE]   = we_q;
    status[CTRL_SEL +: SW] = sel_q;
    rd_val = '1;
    case (addr_i)
      ADDR_WIDTH'(REG_CTRL):  rd_val = status;
      ADDR_WIDTH'(REG_ADDR):  rd_val = addr_q;
      ADDR_WIDTH'(REG_WDATA): rd_val = wdata_q;
      ADDR_WIDTH'(REG_RDATA): rd_val = rdata_q;
      ADDR_WIDTH'(REG_TMO): begin
        rd_val = '0;
        rd_val[15:0] = tmo_q;
      end
      default: rd_val = '1;
    endcase
    dout_d = rden_i ? rd_val : '0;
  end

  // register writes and bus FSM next state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    done_d  = done_q;
    err_d   = err_q;
    to_d    = to_q;
    if (wren_i && !busy) begin
      if (addr_i == ADDR_WIDTH'(REG_ADDR))
        addr_d = data_i;
      if (addr_i == ADDR_WIDTH'(REG_WDATA))
        wdata_d = data_i;
      if (addr_i == ADDR_WIDTH'(REG_TMO))
        tmo_d = data_i[15:0];
    end
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && data_i[CTRL_START]) begin
          we_d    = data_i[CTRL_WE];
          sel_d   = data_i[CTRL_SEL +: SW];
          done_d  = 1'b0;
          err_d   = 1'b0;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (wr_ctrl && data_i[CTRL_ABORT]) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (wb_err_i) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (wb_ack_i) begin
          done_d  = 1'b1;
          if (!we_q)
            rdata_d = wb_dat_i;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (tmo_q != '0 && cnt_d == tmo_q) begin
            done_d  = 1'b1;
            to_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and register file update with sync reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      tmo_q   <= 16'(TIMEOUT_DEFAULT);
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  // host acknowledge tracks every access, even in reset
  always_ff @(posedge clk_i) begin
    ack_q <= rden_i | wren_i;
  end

endmodule

// File: doc/host_wb_master.md
HOST_WB_MASTER -- requirements
Module: host_wb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, host-bus register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, host and Wishbone data/address width.
REQ-003 SHALL have parameter TIMEOUT_DEFAULT, default 255, reset value of the TIMEOUT register.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  sole clock
- rstn_i  in  1  synchronous active-low reset
- wren_i  in  1  host write strobe
- rden_i  in  1  host read strobe
- addr_i  in  ADDR_WIDTH  host register address
- data_i  in  DATA_WIDTH  host write data
- data_o  out  DATA_WIDTH  host read data
- ack_o  out  1  host access acknowledge
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  DATA_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Function
REQ-005 ack_o SHALL equal the registered value of (rden_i OR wren_i), one cycle latency, every access.
REQ-006 data_o SHALL be registered: zero when rden_i is low, otherwise the addressed register value one cycle after rden_i.
REQ-007 Register map:
- 0 CTRL/STATUS. Write: bit0 START, bit1 WE, bit2 ABORT, bits[16+DATA_WIDTH/8-1:16] SEL. Read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TIMEOUT, bit4 WE, bits[15:5]=0, SEL at bits 16+.
- 1 ADDR (rw)
- 2 WDATA (rw)
- 3 RDATA (ro)
- 4 TIMEOUT (rw, low 16 bits; upper bits read 0)
- Any other address SHALL read all ones.
REQ-008 FSM SHALL have states IDLE and ACTIVE; BUSY SHALL be 1 exactly in ACTIVE.
REQ-009 IDLE: a CTRL write with START=1 SHALL latch WE/SEL, clear DONE/ERR/TIMEOUT, clear the wait counter, and enter ACTIVE next cycle.
REQ-010 ACTIVE: wb_cyc_o=wb_stb_o=1; wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o SHALL be driven from ADDR/WDATA/SEL/WE and SHALL stay stable.
REQ-011 ACTIVE with wb_ack_i=1 SHALL set DONE and enter IDLE; if WE=0, wb_dat_i SHALL be captured into RDATA on that cycle.
REQ-012 ACTIVE with wb_err_i=1 SHALL set DONE and ERR, leave RDATA unchanged, and enter IDLE; when ack and err coincide, err SHALL win.
REQ-013 Wait counter SHALL increment each ACTIVE cycle without ack/err; on reaching TIMEOUT (nonzero) it SHALL set DONE and TIMEOUT and enter IDLE; TIMEOUT=0 SHALL disable the timeout.
REQ-014 A CTRL write with ABORT=1 in ACTIVE SHALL enter IDLE next cycle with DONE=1, ERR=1; ABORT in IDLE SHALL be ignored; ABORT SHALL win over a same-cycle ack.
REQ-015 wb_cyc_o/wb_stb_o SHALL deassert the cycle after any ACTIVE exit; no back-to-back cycle without a new START.
REQ-016 While BUSY, writes to ADDR, WDATA, TIMEOUT and CTRL START/WE/SEL SHALL be ignored; host reads SHALL proceed normally.
REQ-017 DONE/ERR/TIMEOUT SHALL be sticky until the next accepted START or reset.
REQ-018 wren_i and rden_i together SHALL perform both; the read SHALL return the pre-write value.

Reset
REQ-019 With rstn_i low at a clock edge: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, ADDR=WDATA=RDATA=0, TIMEOUT=TIMEOUT_DEFAULT, flags 0, data_o=0; ack_o SHALL follow REQ-005 regardless.
REQ-020 Reset during ACTIVE SHALL drop wb_cyc_o/wb_stb_o on that edge without setting any flag.

Structure
REQ-021 Register offsets, CTRL/STATUS bit positions and FSM state encoding SHALL reside in a shared package with the processor-core constants.
REQ-022 No sub-module; single flat module.

Verification
REQ-023 ADDR=0x100, WDATA=0xDEADBEEF, CTRL=0x000F0003; slave acks after 3 cycles -> one 4-cycle STB with we=1, sel=0xF; STATUS=0x000F0012.
REQ-024 ADDR=0x200, CTRL=0x00030001; slave acks with 0x12345678 -> RDATA=0x12345678; STATUS=0x00030002.
REQ-025 Slave asserts ack and err together on cycle 1 -> STATUS ERR=1, DONE=1, RDATA unchanged.
REQ-026 TIMEOUT=5, no slave response -> cyc drops after 5 ACTIVE cycles; STATUS TIMEOUT=1, DONE=1; TIMEOUT=0 -> cyc held 1000 cycles until ABORT, then ERR=1.
REQ-027 Write ADDR=0x300 while BUSY -> ADDR reads original value; read of address 7 -> 0xFFFFFFFF; idle data_o=0.
REQ-028 rstn_i low mid-ACTIVE -> next cycle cyc/stb=0, STATUS=0x00000000, TIMEOUT=255.
